// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared SISC encodings: opcodes, sequencer states, selects, status bits
package sisc_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_RR = 4'h1;
    localparam logic [3:0] OP_ALU_RI = 4'h2;
    localparam logic [3:0] OP_LOD    = 4'h3;
    localparam logic [3:0] OP_STR    = 4'h4;
    localparam logic [3:0] OP_BRA    = 4'h5;
    localparam logic [3:0] OP_BRR    = 4'h6;
    localparam logic [3:0] OP_BNE    = 4'h7;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_ABS = 2'b01;
    localparam logic [1:0] PC_REL = 2'b10;

    localparam logic [1:0] ALUOP_RR   = 2'b00;
    localparam logic [1:0] ALUOP_RI   = 2'b01;
    localparam logic [1:0] ALUOP_PASS = 2'b10;

    // stat is packed {C,N,V,Z}
    localparam int STAT_C = 3;
    localparam int STAT_N = 2;
    localparam int STAT_V = 1;
    localparam int STAT_Z = 0;

    // BRA/BRR take on any selected flag set; BNE takes when none are set
    function automatic logic branch_taken(input logic [3:0] op,
                                          input logic [3:0] mm,
                                          input logic [3:0] stat);
        logic any_hit;
        any_hit = |(mm & stat);
        return (op == OP_BNE) ? !any_hit : any_hit;
    endfunction

endpackage

// File: rtl/sisc_wait_timer.sv
// rtl/sisc_wait_timer.sv - memory handshake wait counter with timeout compare
module sisc_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_f,
    input  logic req,
    input  logic rdy,
    input  logic clr,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // count cycles a request waits; restart on completion, idle or state change
    always_ff @(posedge clk) begin
        if (rst_f || clr || rdy || !req) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // a completion in the final cycle wins over the timeout
    assign timeout = req && !rdy && (wait_cnt == LAST);

endmodule

// File: rtl/sisc_sequencer.sv
// rtl/sisc_sequencer.sv - multi-cycle control sequencer for the SISC datapath
module sisc_sequencer
    import sisc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] instruction,
    input  logic [3:0]  stat,
    input  logic        mem_rdy,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        ir_load,
    output logic        rf_we,
    output logic [1:0]  alu_op,
    output logic        wb_sel,
    output logic        stat_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic        halted,
    output logic        mem_err
);

    state_t     state;
    state_t     state_next;
    logic       mem_err_q;
    logic       timeout;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic       unused_instr;

    assign opcode       = instruction[31:28];
    assign mm           = instruction[27:24];
    assign unused_instr = ^instruction[23:0];

    sisc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_f   (rst_f),
        .req     (mem_req),
        .rdy     (mem_rdy),
        .clr     (state_next != state),
        .timeout (timeout)
    );

    // state register and sticky handshake error flag
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state     <= S_FETCH;
            mem_err_q <= 1'b0;
        end else begin
            state <= state_next;
            if (timeout) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    // next-state and datapath control decode
    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        pc_sel     = PC_INC;
        ir_load    = 1'b0;
        rf_we      = 1'b0;
        alu_op     = ALUOP_RR;
        wb_sel     = 1'b0;
        stat_en    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    ir_load    = 1'b1;
                    pc_write   = 1'b1;
                    pc_sel     = PC_INC;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                state_next = S_FETCH;
                case (opcode)
                    OP_ALU_RR, OP_ALU_RI, OP_LOD, OP_STR: state_next = S_EXECUTE;
                    OP_HLT:                               state_next = S_HALT;
                    OP_BRA, OP_BRR, OP_BNE: begin
                        if (branch_taken(opcode, mm, stat)) begin
                            pc_write = 1'b1;
                            pc_sel   = (opcode == OP_BRR) ? PC_REL : PC_ABS;
                        end
                    end
                    default: state_next = S_FETCH;
                endcase
            end
            S_EXECUTE: begin
                alu_op     = (opcode == OP_ALU_RR) ? ALUOP_RR : ALUOP_RI;
                stat_en    = (opcode == OP_ALU_RR) || (opcode == OP_ALU_RI);
                state_next = ((opcode == OP_LOD) || (opcode == OP_STR)) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STR);
                if (mem_rdy) begin
                    state_next = (opcode == OP_LOD) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_next = S_HALT;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                wb_sel     = (opcode == OP_LOD);
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
        if (rst_f) begin
            pc_write = 1'b0;
            pc_sel   = PC_INC;
            ir_load  = 1'b0;
            rf_we    = 1'b0;
            alu_op   = ALUOP_RR;
            wb_sel   = 1'b0;
            stat_en  = 1'b0;
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            halted   = 1'b0;
        end
    end

    assign mem_err = mem_err_q && !rst_f;

endmodule

// File: tb/tb_sisc_sequencer.sv
// tb/tb_sisc_sequencer.sv - directed self-checking bench for sisc_sequencer
module tb_sisc_sequencer;
    import sisc_pkg::*;

    logic        clk;
    logic        rst_f;
    logic [31:0] instruction;
    logic [3:0]  stat;
    logic        mem_rdy;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        ir_load;
    logic        rf_we;
    logic [1:0]  alu_op;
    logic        wb_sel;
    logic        stat_en;
    logic        mem_req;
    logic        mem_we;
    logic        halted;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    sisc_sequencer #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .instruction (instruction),
        .stat        (stat),
        .mem_rdy     (mem_rdy),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .ir_load     (ir_load),
        .rf_we       (rf_we),
        .alu_op      (alu_op),
        .wb_sel      (wb_sel),
        .stat_en     (stat_en),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .halted      (halted),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, pc_sel, ir_load, rf_we, alu_op, wb_sel, stat_en, mem_req, mem_we, halted, mem_err}
    logic [12:0] outv;
    assign outv = {pc_write, pc_sel, ir_load, rf_we, alu_op, wb_sel, stat_en,
                   mem_req, mem_we, halted, mem_err};

    function automatic logic [12:0] ov(input logic pcw, input logic [1:0] pcs,
                                       input logic irl, input logic rfw,
                                       input logic [1:0] aop, input logic wbs,
                                       input logic sen, input logic mrq,
                                       input logic mwe, input logic hlt,
                                       input logic merr);
        return {pcw, pcs, irl, rfw, aop, wbs, sen, mrq, mwe, hlt, merr};
    endfunction

    logic [12:0] e_zero, e_fetch_rdy, e_fetch_wait, e_exec_rr, e_exec_ri, e_exec_mem;
    logic [12:0] e_wb_alu, e_wb_lod, e_mem_rd, e_mem_wr, e_br_abs, e_br_rel;
    logic [12:0] e_halt, e_err;

    task automatic chk(input string tag, input logic [12:0] exp);
        checks++;
        assert (outv === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, outv, exp);
        end
    endtask

    // apply mem_rdy just after a falling edge, check, then advance one cycle
    task automatic cyc(input string tag, input logic rdy, input logic [12:0] exp);
        mem_rdy = rdy;
        #1;
        chk(tag, exp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_f = 1'b1;
        cyc("reset_outputs", 1'b1, e_zero);
        rst_f = 1'b0;
    endtask

    initial begin
        e_zero       = '0;
        e_fetch_rdy  = ov(1, PC_INC, 1, 0, ALUOP_RR, 0, 0, 1, 0, 0, 0);
        e_fetch_wait = ov(0, PC_INC, 0, 0, ALUOP_RR, 0, 0, 1, 0, 0, 0);
        e_exec_rr    = ov(0, PC_INC, 0, 0, ALUOP_RR, 0, 1, 0, 0, 0, 0);
        e_exec_ri    = ov(0, PC_INC, 0, 0, ALUOP_RI, 0, 1, 0, 0, 0, 0);
        e_exec_mem   = ov(0, PC_INC, 0, 0, ALUOP_RI, 0, 0, 0, 0, 0, 0);
        e_wb_alu     = ov(0, PC_INC, 0, 1, ALUOP_RR, 0, 0, 0, 0, 0, 0);
        e_wb_lod     = ov(0, PC_INC, 0, 1, ALUOP_RR, 1, 0, 0, 0, 0, 0);
        e_mem_rd     = ov(0, PC_INC, 0, 0, ALUOP_RR, 0, 0, 1, 0, 0, 0);
        e_mem_wr     = ov(0, PC_INC, 0, 0, ALUOP_RR, 0, 0, 1, 1, 0, 0);
        e_br_abs     = ov(1, PC_ABS, 0, 0, ALUOP_RR, 0, 0, 0, 0, 0, 0);
        e_br_rel     = ov(1, PC_REL, 0, 0, ALUOP_RR, 0, 0, 0, 0, 0, 0);
        e_halt       = ov(0, PC_INC, 0, 0, ALUOP_RR, 0, 0, 0, 0, 1, 0);
        e_err        = ov(0, PC_INC, 0, 0, ALUOP_RR, 0, 0, 0, 0, 1, 1);

        rst_f       = 1'b1;
        instruction = '0;
        stat        = 4'b0000;
        mem_rdy     = 1'b0;
        @(negedge clk);
        do_reset();

        // ALU_RR: 4 cycles, back in FETCH
        instruction = {OP_ALU_RR, 4'h0, 24'hABCDEF};
        cyc("rr_fetch", 1'b1, e_fetch_rdy);
        cyc("rr_decode", 1'b1, e_zero);
        cyc("rr_execute", 1'b1, e_exec_rr);
        cyc("rr_wb", 1'b1, e_wb_alu);
        cyc("rr_back_fetch", 1'b0, e_fetch_wait);

        // ALU_RI
        instruction = {OP_ALU_RI, 4'h3, 24'h000001};
        cyc("ri_fetch", 1'b1, e_fetch_rdy);
        cyc("ri_decode", 1'b0, e_zero);
        cyc("ri_execute", 1'b1, e_exec_ri);
        cyc("ri_wb", 1'b0, e_wb_alu);

        // LOD with three wait cycles in MEM, rdy on the fourth: 8 cycles total
        instruction = {OP_LOD, 4'h0, 24'h000010};
        cyc("lod_fetch", 1'b1, e_fetch_rdy);
        cyc("lod_decode", 1'b0, e_zero);
        cyc("lod_execute", 1'b0, e_exec_mem);
        cyc("lod_mem_w0", 1'b0, e_mem_rd);
        cyc("lod_mem_w1", 1'b0, e_mem_rd);
        cyc("lod_mem_w2", 1'b0, e_mem_rd);
        cyc("lod_mem_rdy", 1'b1, e_mem_rd);
        cyc("lod_wb", 1'b1, e_wb_lod);
        cyc("lod_back_fetch", 1'b0, e_fetch_wait);

        // STR: no write-back, straight to FETCH after rdy
        instruction = {OP_STR, 4'h0, 24'h000020};
        cyc("str_fetch", 1'b1, e_fetch_rdy);
        cyc("str_decode", 1'b0, e_zero);
        cyc("str_execute", 1'b0, e_exec_mem);
        cyc("str_mem_wait", 1'b0, e_mem_wr);
        cyc("str_mem_rdy", 1'b1, e_mem_wr);
        cyc("str_back_fetch", 1'b0, e_fetch_wait);

        // branches: BRA taken, BRA not taken, BNE taken, BNE not taken, BRR taken
        instruction = {OP_BRA, 4'b0001, 24'h000040};
        stat = 4'b0001;
        cyc("bra_t_fetch", 1'b1, e_fetch_rdy);
        cyc("bra_taken", 1'b1, e_br_abs);
        stat = 4'b0000;
        cyc("bra_nt_fetch", 1'b1, e_fetch_rdy);
        cyc("bra_not_taken", 1'b1, e_zero);
        instruction = {OP_BNE, 4'b0001, 24'h000040};
        cyc("bne_t_fetch", 1'b1, e_fetch_rdy);
        cyc("bne_taken", 1'b1, e_br_abs);
        stat = 4'b1001;
        cyc("bne_nt_fetch", 1'b1, e_fetch_rdy);
        cyc("bne_not_taken", 1'b1, e_zero);
        instruction = {OP_BRR, 4'b1000, 24'h000004};
        cyc("brr_fetch", 1'b1, e_fetch_rdy);
        cyc("brr_taken", 1'b1, e_br_rel);

        // NOP and an illegal opcode both return to FETCH after DECODE
        instruction = {OP_NOP, 4'hF, 24'h0};
        stat = 4'b0000;
        cyc("nop_fetch", 1'b1, e_fetch_rdy);
        cyc("nop_decode", 1'b1, e_zero);
        instruction = {4'h9, 4'hF, 24'h0};
        cyc("ill_fetch", 1'b1, e_fetch_rdy);
        cyc("ill_decode", 1'b1, e_zero);
        cyc("ill_back_fetch", 1'b0, e_fetch_wait);

        // fetch timeout: 16 waiting cycles then HALT with mem_err
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc("to_fetch_wait", 1'b0, e_fetch_wait);
        end
        cyc("to_halted_err", 1'b1, e_err);
        cyc("to_stays_halted", 1'b0, e_err);

        // rdy in the 16th cycle wins: no error
        do_reset();
        instruction = {OP_NOP, 4'h0, 24'h0};
        for (int i = 0; i < 15; i++) begin
            cyc("late_fetch_wait", 1'b0, e_fetch_wait);
        end
        cyc("late_fetch_rdy", 1'b1, e_fetch_rdy);
        cyc("late_decode_no_err", 1'b0, e_zero);
        cyc("late_back_fetch", 1'b0, e_fetch_wait);

        // HLT: stays halted regardless of mem_rdy
        instruction = {OP_HLT, 4'h0, 24'h0};
        cyc("hlt_fetch", 1'b1, e_fetch_rdy);
        cyc("hlt_decode", 1'b1, e_zero);
        cyc("hlt_halt0", 1'b1, e_halt);
        cyc("hlt_halt1", 1'b0, e_halt);
        cyc("hlt_halt2", 1'b1, e_halt);

        // reset in the middle of a LOD memory wait aborts it
        do_reset();
        instruction = {OP_LOD, 4'h0, 24'h000010};
        cyc("abort_fetch", 1'b1, e_fetch_rdy);
        cyc("abort_decode", 1'b0, e_zero);
        cyc("abort_execute", 1'b0, e_exec_mem);
        cyc("abort_mem_wait", 1'b0, e_mem_rd);
        rst_f = 1'b1;
        cyc("abort_in_reset", 1'b1, e_zero);
        rst_f = 1'b0;
        cyc("abort_fetch_after", 1'b0, e_fetch_wait);
        cyc("abort_fetch_after2", 1'b0, e_fetch_wait);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
